// File: rtl/xpb_table_gen.sv
// Runtime builder for the XPB reduction table: entry[i] = (i * 2^SHIFT) mod N, one write per clock.
// Optional start-time modulus validation (err_o port) is enabled by defining XPB_GEN_MOD_CHECK_EN.
module xpb_table_gen #(
    parameter int DATA_W = 1024,
    parameter int IDX_W  = 5,
    parameter int SHIFT  = 300
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [DATA_W-1:0] modulus_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              wr_en_o,
    output logic [IDX_W-1:0]  wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o
`ifdef XPB_GEN_MOD_CHECK_EN
    ,
    output logic              err_o
`endif
);

    localparam int CNT_W = (SHIFT > 1) ? $clog2(SHIFT) : 1;
    localparam logic [CNT_W-1:0] LAST_DBL = CNT_W'((SHIFT > 0) ? SHIFT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        DOUBLE,
        WRITE,
        FIN
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] n_q, n_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  dcnt_q, dcnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic [DATA_W:0]   n_ext;
    logic [DATA_W:0]   dbl_w;
    logic [DATA_W:0]   sum_w;
    logic [DATA_W-1:0] dbl_red;
    logic [DATA_W-1:0] sum_red;
    logic              mod_bad;

    // acc and base stay below N, so a single conditional subtract keeps both results reduced.
    assign n_ext   = {1'b0, n_q};
    assign dbl_w   = {acc_q, 1'b0};
    assign sum_w   = {1'b0, acc_q} + {1'b0, base_q};
    assign dbl_red = (dbl_w >= n_ext) ? DATA_W'(dbl_w - n_ext) : dbl_w[DATA_W-1:0];
    assign sum_red = (sum_w >= n_ext) ? DATA_W'(sum_w - n_ext) : sum_w[DATA_W-1:0];

`ifdef XPB_GEN_MOD_CHECK_EN
    logic err_q, err_d;
    assign mod_bad = (modulus_i < DATA_W'(3)) || !modulus_i[0];
    assign err_o   = err_q;
`else
    assign mod_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        acc_d   = acc_q;
        base_d  = base_q;
        dcnt_d  = dcnt_q;
        idx_d   = idx_q;
`ifdef XPB_GEN_MOD_CHECK_EN
        err_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (mod_bad) begin
`ifdef XPB_GEN_MOD_CHECK_EN
                        err_d = 1'b1;
`endif
                    end else begin
                        n_d    = modulus_i;
                        dcnt_d = '0;
                        idx_d  = '0;
                        if (SHIFT == 0) begin
                            acc_d   = '0;
                            base_d  = DATA_W'(1);
                            state_d = WRITE;
                        end else begin
                            acc_d   = DATA_W'(1);
                            state_d = DOUBLE;
                        end
                    end
                end
            end
            DOUBLE: begin
                acc_d  = dbl_red;
                dcnt_d = dcnt_q + CNT_W'(1);
                // The last doubling yields 2^SHIFT mod N, which becomes the per-entry step.
                if (dcnt_q == LAST_DBL) begin
                    base_d  = dbl_red;
                    acc_d   = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                acc_d = sum_red;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == {IDX_W{1'b1}}) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            n_q     <= '0;
            acc_q   <= '0;
            base_q  <= '0;
            dcnt_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            acc_q   <= acc_d;
            base_q  <= base_d;
            dcnt_q  <= dcnt_d;
            idx_q   <= idx_d;
        end
    end

`ifdef XPB_GEN_MOD_CHECK_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    // Outputs decode straight from state so an asynchronous reset clears them immediately.
    assign busy_o    = (state_q == DOUBLE) || (state_q == WRITE);
    assign done_o    = (state_q == FIN);
    assign wr_en_o   = (state_q == WRITE);
    assign wr_addr_o = (state_q == WRITE) ? idx_q : '0;
    assign wr_data_o = (state_q == WRITE) ? acc_q : '0;

endmodule

// File: tb/tb_xpb_table_gen.sv
// Self-checking bench for xpb_table_gen: small tables, SHIFT=0, mid-run reset and the default 1024-bit build.
// Build with XPB_GEN_MOD_CHECK_EN defined to also exercise the modulus rejection path.
module tb_xpb_table_gen;

    logic clk;
    logic rstN;
    int   tests;
    int   failures;

    logic        startA, busyA, doneA, wrEnA;
    logic [15:0] modA, dataA;
    logic [2:0]  addrA;
    logic        startB, busyB, doneB, wrEnB;
    logic [15:0] modB, dataB;
    logic [2:0]  addrB;
    logic          startC, busyC, doneC, wrEnC;
    logic [1023:0] modC, dataC;
    logic [4:0]    addrC;
`ifdef XPB_GEN_MOD_CHECK_EN
    logic errA, errB, errC;
`endif

    logic [18:0]   sbA[$];
    logic [18:0]   sbB[$];
    logic [1028:0] sbC[$];

    xpb_table_gen #(.DATA_W(16), .IDX_W(3), .SHIFT(4)) dutA (
        .clk_i(clk), .rst_ni(rstN), .start_i(startA), .modulus_i(modA),
        .busy_o(busyA), .done_o(doneA), .wr_en_o(wrEnA), .wr_addr_o(addrA), .wr_data_o(dataA)
`ifdef XPB_GEN_MOD_CHECK_EN
        , .err_o(errA)
`endif
    );

    xpb_table_gen #(.DATA_W(16), .IDX_W(3), .SHIFT(0)) dutB (
        .clk_i(clk), .rst_ni(rstN), .start_i(startB), .modulus_i(modB),
        .busy_o(busyB), .done_o(doneB), .wr_en_o(wrEnB), .wr_addr_o(addrB), .wr_data_o(dataB)
`ifdef XPB_GEN_MOD_CHECK_EN
        , .err_o(errB)
`endif
    );

    xpb_table_gen dutC (
        .clk_i(clk), .rst_ni(rstN), .start_i(startC), .modulus_i(modC),
        .busy_o(busyC), .done_o(doneC), .wr_en_o(wrEnC), .wr_addr_o(addrC), .wr_data_o(dataC)
`ifdef XPB_GEN_MOD_CHECK_EN
        , .err_o(errC)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rstN = 1'b0;
        #1;
        tests++; if (busyA !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busyA); end
        tests++; if (doneA !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", doneA); end
        tests++; if (wrEnA !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr_en: got %b expected 0", wrEnA); end
        tests++; if (addrA !== 3'd0) begin failures++; $display("[TB] FAIL reset_addr: got %0d expected 0", addrA); end
        tests++; if (dataA !== 16'd0) begin failures++; $display("[TB] FAIL reset_data: got %0d expected 0", dataA); end
        tests++; if (busyC !== 1'b0 || wrEnC !== 1'b0) begin failures++; $display("[TB] FAIL reset_c: got busy=%b wr_en=%b expected 0,0", busyC, wrEnC); end
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
    endtask

    // Scenario on the SHIFT=4 / 8-entry instance; disturb adds a mid-run start, a modulus change and a start during done.
    task automatic test_table_a(input string name, input logic [15:0] n, input bit disturb);
        int base;
        int writes;
        logic [18:0] item;
        base   = 16 % int'(n);
        writes = 0;
        sbA.delete();
        for (int i = 0; i < 8; i++) sbA.push_back({3'(i), 16'((i * base) % int'(n))});
        startA = 1'b1;
        modA   = n;
        @(negedge clk);
        startA = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tests++; if (wrEnA !== (k >= 5 && k <= 12)) begin failures++; $display("[TB] FAIL %s wr_en cycle %0d: got %b expected %b", name, k, wrEnA, (k >= 5 && k <= 12)); end
            tests++; if (doneA !== (k == 13)) begin failures++; $display("[TB] FAIL %s done cycle %0d: got %b expected %b", name, k, doneA, (k == 13)); end
            tests++; if (busyA !== (k >= 1 && k <= 12)) begin failures++; $display("[TB] FAIL %s busy cycle %0d: got %b expected %b", name, k, busyA, (k >= 1 && k <= 12)); end
            if (wrEnA === 1'b1) begin
                writes++;
                tests++;
                if (sbA.size() == 0) begin
                    failures++; $display("[TB] FAIL %s extra_write: got addr %0d data %0d expected no write", name, addrA, dataA);
                end else begin
                    item = sbA.pop_front();
                    if ({addrA, dataA} !== item) begin
                        failures++; $display("[TB] FAIL %s entry: got addr %0d data %0d expected addr %0d data %0d", name, addrA, dataA, item[18:16], item[15:0]);
                    end
                end
            end
            if (disturb && k == 3) begin startA = 1'b1; modA = 16'd11; end
            if (disturb && k == 4) startA = 1'b0;
            if (disturb && k == 13) startA = 1'b1;
            if (disturb && k == 14) startA = 1'b0;
            @(negedge clk);
        end
        modA = 16'd0;
        tests++; if (writes != 8) begin failures++; $display("[TB] FAIL %s write_count: got %0d expected 8", name, writes); end
        tests++; if (sbA.size() != 0) begin failures++; $display("[TB] FAIL %s missing_writes: got %0d left expected 0", name, sbA.size()); end
    endtask

    task automatic test_shift0();
        int writes;
        logic [18:0] item;
        writes = 0;
        sbB.delete();
        for (int i = 0; i < 8; i++) sbB.push_back({3'(i), 16'(i % 13)});
        startB = 1'b1;
        modB   = 16'd13;
        @(negedge clk);
        startB = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            tests++; if (wrEnB !== (k >= 1 && k <= 8)) begin failures++; $display("[TB] FAIL shift0 wr_en cycle %0d: got %b expected %b", k, wrEnB, (k >= 1 && k <= 8)); end
            tests++; if (doneB !== (k == 9)) begin failures++; $display("[TB] FAIL shift0 done cycle %0d: got %b expected %b", k, doneB, (k == 9)); end
            if (wrEnB === 1'b1) begin
                writes++;
                tests++;
                if (sbB.size() == 0) begin
                    failures++; $display("[TB] FAIL shift0 extra_write: got addr %0d expected no write", addrB);
                end else begin
                    item = sbB.pop_front();
                    if ({addrB, dataB} !== item) begin
                        failures++; $display("[TB] FAIL shift0 entry: got addr %0d data %0d expected addr %0d data %0d", addrB, dataB, item[18:16], item[15:0]);
                    end
                end
            end
            @(negedge clk);
        end
        tests++; if (writes != 8) begin failures++; $display("[TB] FAIL shift0 write_count: got %0d expected 8", writes); end
    endtask

    task automatic test_reset_midrun();
        startA = 1'b1;
        modA   = 16'd13;
        @(negedge clk);
        startA = 1'b0;
        for (int k = 1; k < 8; k++) @(negedge clk);
        tests++; if (wrEnA !== 1'b1 || addrA !== 3'd3) begin failures++; $display("[TB] FAIL midrun_position: got wr_en %b addr %0d expected 1 addr 3", wrEnA, addrA); end
        #2 rstN = 1'b0;
        #1;
        tests++; if ({busyA, doneA, wrEnA} !== 3'b000) begin failures++; $display("[TB] FAIL midrun_async_ctrl: got %b expected 000", {busyA, doneA, wrEnA}); end
        tests++; if (addrA !== 3'd0 || dataA !== 16'd0) begin failures++; $display("[TB] FAIL midrun_async_bus: got addr %0d data %0d expected 0 0", addrA, dataA); end
        @(negedge clk);
        rstN = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            tests++; if (wrEnA !== 1'b0 || busyA !== 1'b0) begin failures++; $display("[TB] FAIL midrun_after_release: got wr_en %b busy %b expected 0 0", wrEnA, busyA); end
        end
        test_table_a("after_reset", 16'd13, 1'b0);
    endtask

    // Expected entries come from direct wide arithmetic (i << 300) mod N rather than iterative doubling.
    task automatic test_defaults(input string name, input logic [1023:0] n);
        int writes;
        logic [1029:0] p;
        logic [1028:0] item;
        writes = 0;
        sbC.delete();
        for (int i = 0; i < 32; i++) begin
            p = 1030'(i) << 300;
            p = p % {6'd0, n};
            sbC.push_back({5'(i), p[1023:0]});
        end
        startC = 1'b1;
        modC   = n;
        @(negedge clk);
        startC = 1'b0;
        for (int k = 1; k <= 335; k++) begin
            if (k == 300 || k == 301) begin
                tests++; if (wrEnC !== (k == 301)) begin failures++; $display("[TB] FAIL %s wr_en_edge cycle %0d: got %b expected %b", name, k, wrEnC, (k == 301)); end
            end
            if (k == 332 || k == 333) begin
                tests++; if (doneC !== (k == 333)) begin failures++; $display("[TB] FAIL %s done cycle %0d: got %b expected %b", name, k, doneC, (k == 333)); end
            end
            if (wrEnC === 1'b1) begin
                writes++;
                tests++;
                if (sbC.size() == 0) begin
                    failures++; $display("[TB] FAIL %s extra_write: got addr %0d expected no write", name, addrC);
                end else begin
                    item = sbC.pop_front();
                    if ({addrC, dataC} !== item) begin
                        failures++; $display("[TB] FAIL %s entry: got addr %0d data %h expected addr %0d data %h", name, addrC, dataC[63:0], item[1028:1024], item[63:0]);
                    end
                end
            end
            @(negedge clk);
        end
        tests++; if (writes != 32) begin failures++; $display("[TB] FAIL %s write_count: got %0d expected 32", name, writes); end
    endtask

`ifdef XPB_GEN_MOD_CHECK_EN
    task automatic test_mod_check();
        startA = 1'b1;
        modA   = 16'd12;
        @(negedge clk);
        startA = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tests++; if (errA !== (k == 1)) begin failures++; $display("[TB] FAIL modchk err cycle %0d: got %b expected %b", k, errA, (k == 1)); end
            tests++; if ({busyA, wrEnA, doneA} !== 3'b000) begin failures++; $display("[TB] FAIL modchk idle cycle %0d: got %b expected 000", k, {busyA, wrEnA, doneA}); end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        logic [1023:0] nBig;
        tests    = 0;
        failures = 0;
        startA = 1'b0; modA = '0;
        startB = 1'b0; modB = '0;
        startC = 1'b0; modC = '0;
        test_reset();
        test_table_a("n13", 16'd13, 1'b0);
        test_table_a("n7_wrap", 16'd7, 1'b0);
        test_shift0();
        test_table_a("back_to_back", 16'd13, 1'b1);
        test_reset_midrun();
        nBig = '0;
        for (int j = 0; j < 32; j++) nBig[j*32 +: 32] = $urandom;
        nBig[0]    = 1'b1;
        nBig[1023] = 1'b1;
        test_defaults("full_width", nBig);
        nBig = '0;
        for (int j = 0; j < 9; j++) nBig[j*32 +: 32] = $urandom;
        nBig[0]   = 1'b1;
        nBig[287] = 1'b1;
        test_defaults("reducing", nBig);
`ifdef XPB_GEN_MOD_CHECK_EN
        test_mod_check();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
